// File: rtl/free_list_pkg.sv
// Shared types and sizing for the physical-register free list and RENAME.
package free_list_pkg;

    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned NUM_AREGS = 32;
    localparam int unsigned WIDTH     = 2;

    localparam int unsigned DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int unsigned PREG_W = $clog2(NUM_PREGS);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned SLOT_W = $clog2(WIDTH + 1);

    typedef logic [PREG_W-1:0] p_reg;
    typedef logic [PTR_W-1:0]  fl_ptr;
    typedef logic [CNT_W-1:0]  fl_cnt;
    typedef logic [SLOT_W-1:0] slot_cnt;

    // Advance a ring pointer by n (n <= WIDTH <= DEPTH), wrapping modulo DEPTH.
    function automatic fl_ptr ptr_add(fl_ptr ptr, slot_cnt n);
        int unsigned s;
        s = 32'(ptr) + 32'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return fl_ptr'(s);
    endfunction

endpackage

// File: rtl/free_list_compact.sv
// Prefix popcount: offset[i] = number of set mask bits below slot i.
module free_list_compact
    import free_list_pkg::*;
(
    input  logic [WIDTH-1:0]    mask,
    output slot_cnt [WIDTH-1:0] offset,
    output slot_cnt             total
);

    // running count of set bits, slot 0 first
    always_comb begin
        slot_cnt acc;
        acc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            offset[i] = acc;
            acc       = acc + slot_cnt'(mask[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of unallocated pregs, WIDTH-wide
// allocate and release per cycle. Optional FREE_LIST_DOUBLE_FREE_CHECK_EN adds
// an is_free bitmap and a sticky o_err output.
module free_list
    import free_list_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_alloc_req,
    output p_reg [WIDTH-1:0] o_free_PRegs,
    output logic             o_alloc_ok,
    input  logic [WIDTH-1:0] i_release_valid,
    input  p_reg [WIDTH-1:0] i_release_PRegs,
    output fl_cnt            o_count,
    output logic             o_empty
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    ,
    output logic             o_err
`endif
);

    p_reg  entry [DEPTH];
    fl_ptr head;
    fl_ptr tail;
    fl_cnt count;

    slot_cnt [WIDTH-1:0] alloc_off;
    slot_cnt [WIDTH-1:0] rel_off;
    slot_cnt             n_req;
    slot_cnt             n_rel;
    slot_cnt             alloc_n;
    slot_cnt             n_rel_acc;
    logic [WIDTH-1:0]    rel_mask;
    logic [WIDTH-1:0]    rel_take;
    int unsigned         room;
    fl_cnt               count_next;

    free_list_compact u_alloc_compact (
        .mask   (i_alloc_req),
        .offset (alloc_off),
        .total  (n_req)
    );

    free_list_compact u_rel_compact (
        .mask   (rel_mask),
        .offset (rel_off),
        .total  (n_rel)
    );

    // p0 is never renamed, so its release is filtered out before compaction
    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rel_mask[i] = i_release_valid[i] && (i_release_PRegs[i] != '0);
        end
    end

    // offer compacted entries from head; all-or-nothing grant
    always_comb begin
        o_alloc_ok = (fl_cnt'(n_req) <= count);
        alloc_n    = o_alloc_ok ? n_req : '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_free_PRegs[i] = entry[ptr_add(head, alloc_off[i])];
        end
    end

    // entries vacated by this cycle's allocation are reusable, so releases fill up to that room and the rest drop
    always_comb begin
        room = DEPTH - 32'(count) + 32'(alloc_n);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rel_take[i] = rel_mask[i] && (32'(rel_off[i]) < room);
        end
        n_rel_acc  = (32'(n_rel) > room) ? slot_cnt'(room) : n_rel;
        count_next = count - fl_cnt'(alloc_n) + fl_cnt'(n_rel_acc);
    end

    // ring storage, pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                entry[k] <= p_reg'(NUM_AREGS + k);
            end
            head  <= '0;
            tail  <= '0;
            count <= fl_cnt'(DEPTH);
        end else begin
            if (o_alloc_ok) head <= ptr_add(head, n_req);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (rel_take[i]) entry[ptr_add(tail, rel_off[i])] <= i_release_PRegs[i];
            end
            tail  <= ptr_add(tail, n_rel_acc);
            count <= count_next;
        end
    end

    assign o_count = count;
    assign o_empty = (count == '0);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_PREGS-1:0] is_free;
    logic                 err_now;

    // flag re-free of a free preg, duplicate release in one cycle, or overflow
    always_comb begin
        err_now = (32'(n_rel) > room);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (rel_mask[i] && is_free[i_release_PRegs[i]]) err_now = 1'b1;
            for (int unsigned j = i + 1; j < WIDTH; j++) begin
                if (rel_mask[i] && rel_mask[j] && (i_release_PRegs[i] == i_release_PRegs[j]))
                    err_now = 1'b1;
            end
        end
    end

    // track ownership: clear on allocation, set on accepted release; error is sticky
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            is_free <= {{DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
            o_err   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (o_alloc_ok && i_alloc_req[i]) is_free[o_free_PRegs[i]] <= 1'b0;
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (rel_take[i]) is_free[i_release_PRegs[i]] <= 1'b1;
            end
            if (err_now) o_err <= 1'b1;
        end
    end
`endif

endmodule
